// File: rtl/ctrl_pkg.sv
// Shared encodings for the multicycle RV32I control path: ALU ops, opcodes, FSM states.
package ctrl_pkg;

  localparam logic [3:0] ALUOP_AND = 4'b0000;
  localparam logic [3:0] ALUOP_OR  = 4'b0001;
  localparam logic [3:0] ALUOP_ADD = 4'b0010;
  localparam logic [3:0] ALUOP_SLT = 4'b0100;
  localparam logic [3:0] ALUOP_XOR = 4'b0101;
  localparam logic [3:0] ALUOP_SUB = 4'b0110;
  localparam logic [3:0] ALUOP_LSR = 4'b1000;
  localparam logic [3:0] ALUOP_LSL = 4'b1001;
  localparam logic [3:0] ALUOP_ASR = 4'b1010;

  localparam logic [6:0] OPC_RTYPE  = 7'b0110011;
  localparam logic [6:0] OPC_IALU   = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  localparam logic [2:0] F3_WORD = 3'b010;
  localparam logic [2:0] F3_BEQ  = 3'b000;

  typedef enum logic [2:0] {
    S_IF  = 3'd0,
    S_ID  = 3'd1,
    S_EX  = 3'd2,
    S_MEM = 3'd3,
    S_WB  = 3'd4
  } state_e;

  // Instructions whose funct7 field is an opcode extension rather than immediate bits.
  function automatic logic funct7_is_opcode(input logic [6:0] opcode, input logic [2:0] funct3);
    return (opcode == OPC_RTYPE) || ((opcode == OPC_IALU) && (funct3[1:0] == 2'b01));
  endfunction

endpackage

// File: rtl/alu_op_decoder.sv
// Maps (opcode, funct3, funct7[5]) to an ALU operation and flags unsupported combinations.
module alu_op_decoder
  import ctrl_pkg::*;
(
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic       funct7_5,
  output logic [3:0] alu_op,
  output logic       legal
);

  logic is_r;
  assign is_r = (opcode == OPC_RTYPE);

  always_comb begin
    alu_op = ALUOP_ADD;
    legal  = 1'b0;
    case (opcode)
      OPC_RTYPE, OPC_IALU: begin
        legal = 1'b1;
        // For I-ALU non-shifts funct7[5] is an immediate bit and must not affect decode.
        case (funct3)
          3'b000: alu_op = (is_r && funct7_5) ? ALUOP_SUB : ALUOP_ADD;
          3'b001: begin
            alu_op = ALUOP_LSL;
            legal  = !funct7_5;
          end
          3'b010: begin
            alu_op = ALUOP_SLT;
            legal  = !(is_r && funct7_5);
          end
          3'b100: begin
            alu_op = ALUOP_XOR;
            legal  = !(is_r && funct7_5);
          end
          3'b101: alu_op = funct7_5 ? ALUOP_ASR : ALUOP_LSR;
          3'b110: begin
            alu_op = ALUOP_OR;
            legal  = !(is_r && funct7_5);
          end
          3'b111: begin
            alu_op = ALUOP_AND;
            legal  = !(is_r && funct7_5);
          end
          default: legal = 1'b0;
        endcase
      end
      OPC_LOAD, OPC_STORE: legal = (funct3 == F3_WORD);
      OPC_BRANCH: begin
        alu_op = ALUOP_SUB;
        legal  = (funct3 == F3_BEQ);
      end
      default: legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle IF/ID/EX/MEM/WB control FSM with memory handshake timeout and retire counter.
module multicycle_ctrl
  import ctrl_pkg::*;
#(
  parameter int unsigned CNT_W       = 32,
  parameter int unsigned MEM_TIMEOUT = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      instr,
  input  logic             zero,
  input  logic             mem_ready,
  output logic [3:0]       alu_op,
  output logic             alu_src,
  output logic             ir_write,
  output logic             reg_write,
  output logic             mem_to_reg,
  output logic             mem_read,
  output logic             mem_write,
  output logic             pc_write,
  output logic             pc_src,
  output logic             illegal,
  output logic             bus_err,
  output logic [CNT_W-1:0] retired
);

  localparam bit          TmoEn   = (MEM_TIMEOUT != 0);
  localparam logic [31:0] TmoLast = 32'(MEM_TIMEOUT - 1);

  state_e           state_q, state_d;
  logic [31:0]      wait_q, wait_d;
  logic [CNT_W-1:0] retired_q;
  logic             retire;

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [3:0] dec_op;
  logic       dec_legal;
  logic       f7_rsvd_ok;
  logic       instr_legal;
  logic       is_lw, is_sw, is_beq, is_r;
  logic       timed_out;
  logic       unused_instr_bits;

  assign opcode = instr[6:0];
  assign funct3 = instr[14:12];
  assign unused_instr_bits = ^{instr[24:15], instr[11:7]};

  alu_op_decoder u_dec (
    .opcode   (opcode),
    .funct3   (funct3),
    .funct7_5 (instr[30]),
    .alu_op   (dec_op),
    .legal    (dec_legal)
  );

  // Only funct7[5] carries meaning; any other set bit marks an unsupported extension.
  assign f7_rsvd_ok  = !(funct7_is_opcode(opcode, funct3) && (instr[31] || (instr[29:25] != 5'b0)));
  assign instr_legal = dec_legal && f7_rsvd_ok;

  assign is_r   = (opcode == OPC_RTYPE);
  assign is_lw  = (opcode == OPC_LOAD);
  assign is_sw  = (opcode == OPC_STORE);
  assign is_beq = (opcode == OPC_BRANCH);

  assign timed_out = TmoEn && (wait_q == TmoLast) && !mem_ready;

  always_comb begin
    state_d    = state_q;
    wait_d     = wait_q;
    retire     = 1'b0;
    alu_op     = ALUOP_ADD;
    alu_src    = 1'b0;
    ir_write   = 1'b0;
    reg_write  = 1'b0;
    mem_to_reg = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    pc_write   = 1'b0;
    pc_src     = 1'b0;
    illegal    = 1'b0;
    bus_err    = 1'b0;

    case (state_q)
      S_IF: begin
        ir_write = 1'b1;
        state_d  = S_ID;
      end
      S_ID: begin
        if (!instr_legal) begin
          illegal  = 1'b1;
          pc_write = 1'b1;
          state_d  = S_IF;
        end else begin
          state_d = S_EX;
        end
      end
      S_EX: begin
        alu_op  = dec_op;
        alu_src = !is_r && !is_beq;
        if (is_beq) begin
          pc_write = 1'b1;
          pc_src   = zero;
          retire   = 1'b1;
          state_d  = S_IF;
        end else if (is_lw || is_sw) begin
          state_d = S_MEM;
        end else begin
          state_d = S_WB;
        end
      end
      S_MEM: begin
        mem_read  = is_lw;
        mem_write = is_sw;
        if (mem_ready) begin
          wait_d = '0;
          if (is_sw) begin
            pc_write = 1'b1;
            retire   = 1'b1;
            state_d  = S_IF;
          end else begin
            state_d = S_WB;
          end
        end else if (timed_out) begin
          // Final waiting cycle: the request is still up now and drops as we return to IF.
          wait_d   = '0;
          bus_err  = 1'b1;
          pc_write = 1'b1;
          state_d  = S_IF;
        end else begin
          wait_d = wait_q + 32'd1;
        end
      end
      S_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = is_lw;
        pc_write   = 1'b1;
        retire     = 1'b1;
        state_d    = S_IF;
      end
      default: state_d = S_IF;
    endcase

    // Reset masks every control line in the very cycle it is sampled.
    if (!rst) begin
      alu_op     = 4'b0000;
      alu_src    = 1'b0;
      ir_write   = 1'b0;
      reg_write  = 1'b0;
      mem_to_reg = 1'b0;
      mem_read   = 1'b0;
      mem_write  = 1'b0;
      pc_write   = 1'b0;
      pc_src     = 1'b0;
      illegal    = 1'b0;
      bus_err    = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= S_IF;
      wait_q    <= '0;
      retired_q <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      if (retire) begin
        retired_q <= retired_q + {{(CNT_W-1){1'b0}}, 1'b1};
      end
    end
  end

  assign retired = rst ? retired_q : '0;

endmodule
